// File: rtl/code_lock_ctrl_pkg.sv
// code_lock_ctrl_pkg: shared FSM state type and BCD digit helpers
// for the code-entry controller (no ports).
package code_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_FAIL    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  function automatic logic [DIGIT_W-1:0] bcd_inc(
    input logic [DIGIT_W-1:0] d
  );
    return (d == DIGIT_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// code_lock_ctrl_if: key pulses in, entry/status indications out.
// master drives keys, slave (the controller) drives status.
interface code_lock_ctrl_if
  import code_lock_ctrl_pkg::*;
#(
  parameter int CODE_DIGITS = 4
);
  logic                           key_inc;
  logic                           key_next;
  logic                           key_enter;
  logic                           key_clear;
  logic [DIGIT_W*CODE_DIGITS-1:0] digits;
  logic [2:0]                     cursor;
  logic                           unlock;
  logic                           alarm;
  logic                           err_pulse;
  logic                           code_updated;
  logic [1:0]                     fail_cnt;

  modport master (
    output key_inc, key_next, key_enter, key_clear,
    input  digits, cursor, unlock, alarm,
    input  err_pulse, code_updated, fail_cnt
  );

  modport slave (
    input  key_inc, key_next, key_enter, key_clear,
    output digits, cursor, unlock, alarm,
    output err_pulse, code_updated, fail_cnt
  );
endinterface

// File: rtl/code_digit_buf.sv
// code_digit_buf: BCD entry buffer and edit cursor.
// Ports: clk, rst, inc/next/clr strobes in; digits, cursor out.
module code_digit_buf
  import code_lock_ctrl_pkg::*;
#(
  parameter int CODE_DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inc,
  input  logic                           next,
  input  logic                           clr,
  output logic [DIGIT_W*CODE_DIGITS-1:0] digits,
  output logic [2:0]                     cursor
);

  localparam logic [2:0] CUR_LAST = 3'(CODE_DIGITS - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digits <= '0;
      cursor <= '0;
    end else if (next) begin
      cursor <= (cursor == CUR_LAST) ? 3'd0 : cursor + 3'd1;
    end else if (inc) begin
      for (int i = 0; i < CODE_DIGITS; i++) begin
        if (cursor == 3'(i)) begin
          digits[i*DIGIT_W +: DIGIT_W] <=
            bcd_inc(digits[i*DIGIT_W +: DIGIT_W]);
        end
      end
    end
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: code entry, verification, unlock and lockout FSM.
// Ports: clk, rst (sync, high), bus (slave: keys in, status out).
module code_lock_ctrl
  import code_lock_ctrl_pkg::*;
#(
  parameter int          CODE_DIGITS  = 4,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234,
  parameter int          MAX_FAILS    = 3,
  parameter int unsigned OPEN_CYCLES  = 625_000_000,
  parameter int unsigned LOCK_CYCLES  = 1_250_000_000
) (
  input logic              clk,
  input logic              rst,
  code_lock_ctrl_if.slave  bus
);

  localparam int W = DIGIT_W * CODE_DIGITS;
  localparam logic [W-1:0] CODE_RST  = DEFAULT_CODE[W-1:0];
  localparam logic [31:0]  OPEN_LAST = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0]  LOCK_LAST = 32'(LOCK_CYCLES - 1);
  localparam logic [1:0]   FAIL_LIM  = 2'(MAX_FAILS);

  state_t      state;
  logic [31:0] tmr;
  logic [W-1:0] code_q;
  logic [1:0]  fail_q;
  logic        unlock_q, alarm_q, err_q, upd_q;

  logic key_act;
  logic k_clr, k_ent, k_nxt, k_inc;
  logic tmr_done, match, lock_hit, buf_clr;

  assign key_act = (state == S_ENTRY) || (state == S_OPEN);

  // One key acts per cycle: clear > enter > next > inc.
  always_comb begin
    k_clr = 1'b0;
    k_ent = 1'b0;
    k_nxt = 1'b0;
    k_inc = 1'b0;
    if (key_act) begin
      priority case (1'b1)
        bus.key_clear: k_clr = 1'b1;
        bus.key_enter: k_ent = 1'b1;
        bus.key_next:  k_nxt = 1'b1;
        bus.key_inc:   k_inc = 1'b1;
        default: ;
      endcase
    end
  end

  assign tmr_done = (state == S_OPEN) ? (tmr == OPEN_LAST)
                                      : (tmr == LOCK_LAST);
  assign match    = (bus.digits == code_q);
  assign lock_hit = ((fail_q + 2'd1) == FAIL_LIM);

  // Buffer is wiped on clear and on every edge entering ENTRY or OPEN.
  assign buf_clr = k_clr
                 | ((state == S_CHECK) && match)
                 | ((state == S_FAIL) && !lock_hit)
                 | ((state == S_OPEN) && (k_ent || tmr_done))
                 | ((state == S_LOCKOUT) && tmr_done);

  code_digit_buf #(
    .CODE_DIGITS (CODE_DIGITS)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .inc    (k_inc),
    .next   (k_nxt),
    .clr    (buf_clr),
    .digits (bus.digits),
    .cursor (bus.cursor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ENTRY;
      tmr      <= '0;
      code_q   <= CODE_RST;
      fail_q   <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      upd_q <= 1'b0;
      tmr   <= tmr + 32'd1;
      unique case (state)
        S_ENTRY: begin
          if (k_ent) state <= S_CHECK;
        end
        S_CHECK: begin
          if (match) begin
            state    <= S_OPEN;
            unlock_q <= 1'b1;
            fail_q   <= '0;
            tmr      <= '0;
          end else begin
            state <= S_FAIL;
            err_q <= 1'b1;
          end
        end
        S_FAIL: begin
          if (lock_hit) begin
            state   <= S_LOCKOUT;
            alarm_q <= 1'b1;
            fail_q  <= FAIL_LIM;
            tmr     <= '0;
          end else begin
            state  <= S_ENTRY;
            fail_q <= fail_q + 2'd1;
          end
        end
        S_OPEN: begin
          // enter beats a same-cycle timeout
          if (k_ent) begin
            code_q   <= bus.digits;
            upd_q    <= 1'b1;
            unlock_q <= 1'b0;
            state    <= S_ENTRY;
          end else if (tmr_done) begin
            unlock_q <= 1'b0;
            state    <= S_ENTRY;
          end
        end
        S_LOCKOUT: begin
          if (tmr_done) begin
            alarm_q <= 1'b0;
            fail_q  <= '0;
            state   <= S_ENTRY;
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

  assign bus.unlock       = unlock_q;
  assign bus.alarm        = alarm_q;
  assign bus.err_pulse    = err_q;
  assign bus.code_updated = upd_q;
  assign bus.fail_cnt     = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: vectors, directed sequences and random keys
// checked against a decimal-valued reference model of the lock.
module tb_code_lock_ctrl;

  localparam int N       = 4;
  localparam int OPEN_C  = 20;
  localparam int LOCK_C  = 40;
  localparam int OPEN_C2 = 64;
  localparam int MAXF    = 3;

  localparam logic [3:0] K_INC  = 4'b0001;
  localparam logic [3:0] K_NEXT = 4'b0010;
  localparam logic [3:0] K_ENT  = 4'b0100;
  localparam logic [3:0] K_CLR  = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic k_inc = 1'b0, k_next = 1'b0;
  logic k_enter = 1'b0, k_clear = 1'b0;

  code_lock_ctrl_if #(.CODE_DIGITS(N)) bus ();
  code_lock_ctrl_if #(.CODE_DIGITS(N)) bus2 ();

  assign bus.key_inc    = k_inc;
  assign bus.key_next   = k_next;
  assign bus.key_enter  = k_enter;
  assign bus.key_clear  = k_clear;
  assign bus2.key_inc   = k_inc;
  assign bus2.key_next  = k_next;
  assign bus2.key_enter = k_enter;
  assign bus2.key_clear = k_clear;

  code_lock_ctrl #(
    .CODE_DIGITS  (N),
    .DEFAULT_CODE (32'h0000_1234),
    .MAX_FAILS    (MAXF),
    .OPEN_CYCLES  (OPEN_C),
    .LOCK_CYCLES  (LOCK_C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Longer open window so a full 5678 can be keyed in while open.
  code_lock_ctrl #(
    .CODE_DIGITS  (N),
    .DEFAULT_CODE (32'h0000_1234),
    .MAX_FAILS    (MAXF),
    .OPEN_CYCLES  (OPEN_C2),
    .LOCK_CYCLES  (LOCK_C)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nprint = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: digits as integers, code as a decimal number,
  // open/lockout as remaining-cycle countdowns.
  localparam int M_IDLE = 0, M_CHK = 1, M_OPEN = 2;
  localparam int M_BAD = 3, M_LOCK = 4;

  int md[N];
  int mcur, mcode, mmode, mleft, mfail;
  bit merr, mupd;

  function automatic int m_value();
    int v = 0;
    int p = 1;
    for (int i = 0; i < N; i++) begin
      v += md[i] * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic void m_clr();
    for (int i = 0; i < N; i++) md[i] = 0;
    mcur = 0;
  endfunction

  function automatic void m_reset();
    m_clr();
    mcode = 1234;
    mmode = M_IDLE;
    mleft = 0;
    mfail = 0;
    merr  = 0;
    mupd  = 0;
  endfunction

  function automatic void m_step(bit r, bit inc, bit nx,
                                 bit en, bit cl);
    merr = 0;
    mupd = 0;
    if (r) begin
      m_reset();
      return;
    end
    case (mmode)
      M_IDLE, M_OPEN: begin
        if (cl) m_clr();
        else if (en) begin
          if (mmode == M_IDLE) mmode = M_CHK;
          else begin
            mcode = m_value();
            mupd  = 1;
            mmode = M_IDLE;
            m_clr();
          end
        end else if (nx) mcur = (mcur + 1) % N;
        else if (inc) md[mcur] = (md[mcur] + 1) % 10;
        if (mmode == M_OPEN) begin
          if (mleft == 1) begin
            mmode = M_IDLE;
            m_clr();
          end else mleft--;
        end
      end
      M_CHK: begin
        if (m_value() == mcode) begin
          mmode = M_OPEN;
          mleft = OPEN_C;
          mfail = 0;
          m_clr();
        end else begin
          mmode = M_BAD;
          merr  = 1;
        end
      end
      M_BAD: begin
        if (mfail + 1 == MAXF) begin
          mmode = M_LOCK;
          mleft = LOCK_C;
          mfail = MAXF;
        end else begin
          mfail++;
          mmode = M_IDLE;
          m_clr();
        end
      end
      default: begin
        if (mleft == 1) begin
          mmode = M_IDLE;
          mfail = 0;
          m_clr();
        end else mleft--;
      end
    endcase
  endfunction

  function automatic logic [24:0] m_exp();
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < N; i++) d[i*4 +: 4] = 4'(md[i]);
    return {d, 3'(mcur), mmode == M_OPEN, mmode == M_LOCK,
            merr, mupd, 2'(mfail)};
  endfunction

  task automatic tick();
    logic [24:0] act, exp;
    @(posedge clk);
    m_step(rst, k_inc, k_next, k_enter, k_clear);
    #1;
    act = {bus.digits, bus.cursor, bus.unlock, bus.alarm,
           bus.err_pulse, bus.code_updated, bus.fail_cnt};
    exp = m_exp();
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 10) begin
        nprint++;
        $display("FAIL model t=%0t act=%h exp=%h", $time, act, exp);
      end
    end
  endtask

  task automatic press(logic [3:0] k);
    {k_clear, k_enter, k_next, k_inc} = k;
    tick();
    {k_clear, k_enter, k_next, k_inc} = 4'b0;
  endtask

  task automatic type_code(int c);
    int v = c;
    for (int i = 0; i < N; i++) begin
      repeat (v % 10) press(K_INC);
      v = v / 10;
      if (i < N - 1) press(K_NEXT);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  keys;
    logic [15:0] dig;
    logic [2:0]  cur;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vec_t v;
    m_reset();

    // reset state
    do_reset();
    tick();
    chk("rst_digits", bus.digits, 0);
    chk("rst_cursor", bus.cursor, 0);
    chk("rst_unlock", bus.unlock, 0);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_err", bus.err_pulse, 0);
    chk("rst_upd", bus.code_updated, 0);
    chk("rst_fail", bus.fail_cnt, 0);

    // correct code, unlock window
    type_code(1234);
    chk("typed_1234", bus.digits, 32'h1234);
    press(K_ENT);
    chk("check_no_unlock", bus.unlock, 0);
    tick();
    chk("unlock_n2", bus.unlock, 1);
    cnt = 1;
    while (bus.unlock && cnt < 200) begin
      tick();
      if (bus.unlock) cnt++;
    end
    chk("unlock_len", cnt, OPEN_C);
    chk("open_exit_digits", bus.digits, 0);

    // three wrong attempts, lockout
    for (int a = 1; a <= 3; a++) begin
      press(K_ENT);
      tick();
      chk($sformatf("err_try%0d", a), bus.err_pulse, 1);
      tick();
      if (a < 3) chk($sformatf("fail_try%0d", a), bus.fail_cnt, a);
      else begin
        chk("alarm_on", bus.alarm, 1);
        chk("fail_lock", bus.fail_cnt, MAXF);
      end
    end
    cnt = 1;
    while (bus.alarm && cnt < 200) begin
      {k_clear, k_enter, k_next, k_inc} = 4'($urandom_range(0, 15));
      tick();
      {k_clear, k_enter, k_next, k_inc} = 4'b0;
      if (bus.alarm) cnt++;
    end
    chk("alarm_len", cnt, LOCK_C);
    chk("lock_exit_fail", bus.fail_cnt, 0);

    // vector table: inc wrap, cursor wrap, key priority
    for (int i = 1; i <= 9; i++) begin
      v = '{K_INC, 16'(i), 3'd0, 1'b0};
      tbl.push_back(v);
    end
    v = '{K_INC, 16'h0000, 3'd0, 1'b0};         tbl.push_back(v);
    v = '{K_NEXT, 16'h0000, 3'd1, 1'b0};        tbl.push_back(v);
    v = '{K_NEXT, 16'h0000, 3'd2, 1'b0};        tbl.push_back(v);
    v = '{K_NEXT, 16'h0000, 3'd3, 1'b0};        tbl.push_back(v);
    v = '{K_NEXT, 16'h0000, 3'd0, 1'b0};        tbl.push_back(v);
    v = '{K_INC, 16'h0001, 3'd0, 1'b0};         tbl.push_back(v);
    v = '{K_CLR | K_INC, 16'h0000, 3'd0, 1'b0}; tbl.push_back(v);
    v = '{K_NEXT, 16'h0000, 3'd1, 1'b0};        tbl.push_back(v);
    v = '{K_INC, 16'h0010, 3'd1, 1'b0};         tbl.push_back(v);
    v = '{K_ENT | K_NEXT, 16'h0010, 3'd1, 1'b0}; tbl.push_back(v);
    v = '{4'b0, 16'h0010, 3'd1, 1'b1};          tbl.push_back(v);
    v = '{4'b0, 16'h0000, 3'd0, 1'b0};          tbl.push_back(v);
    foreach (tbl[i]) begin
      {k_clear, k_enter, k_next, k_inc} = tbl[i].keys;
      tick();
      {k_clear, k_enter, k_next, k_inc} = 4'b0;
      chk($sformatf("vec%0d_dig", i), bus.digits, tbl[i].dig);
      chk($sformatf("vec%0d_cur", i), bus.cursor, tbl[i].cur);
      chk($sformatf("vec%0d_err", i), bus.err_pulse, tbl[i].err);
    end

    // code change while open (long-window instance)
    do_reset();
    type_code(1234);
    press(K_ENT);
    tick();
    chk("b2_unlock", bus2.unlock, 1);
    type_code(5678);
    press(K_ENT);
    chk("b2_code_upd", bus2.code_updated, 1);
    chk("b2_unlock_off", bus2.unlock, 0);
    tick();
    chk("b2_upd_pulse", bus2.code_updated, 0);
    type_code(1234);
    press(K_ENT);
    tick();
    chk("b2_old_err", bus2.err_pulse, 1);
    tick();
    type_code(5678);
    press(K_ENT);
    tick();
    chk("b2_new_unlock", bus2.unlock, 1);

    // reset in lockout cycle 10 restores default code
    repeat (OPEN_C2 + 6) tick();
    for (int a = 0; a < 3; a++) begin
      press(K_ENT);
      tick();
      tick();
    end
    chk("b2_alarm", bus2.alarm, 1);
    repeat (9) tick();
    chk("b2_alarm_c10", bus2.alarm, 1);
    do_reset();
    chk("b2_rst_alarm", bus2.alarm, 0);
    chk("b2_rst_fail", bus2.fail_cnt, 0);
    chk("b2_rst_unlock", bus2.unlock, 0);
    chk("b2_rst_digits", bus2.digits, 0);
    type_code(1234);
    press(K_ENT);
    tick();
    chk("b2_default_back", bus2.unlock, 1);

    // random keys, with periodic correct-code attempts
    do_reset();
    for (int r = 0; r < 12; r++) begin
      cnt = 0;
      while (mmode != M_IDLE && cnt < 200) begin
        tick();
        cnt++;
      end
      chk($sformatf("rnd%0d_idle", r), bus.alarm | bus.unlock, 0);
      press(K_CLR);
      type_code(mcode);
      press(K_ENT);
      tick();
      chk($sformatf("rnd%0d_unlock", r), bus.unlock, 1);
      for (int c = 0; c < 200; c++) begin
        k_inc   = ($urandom_range(0, 99) < 35);
        k_next  = ($urandom_range(0, 99) < 12);
        k_enter = ($urandom_range(0, 99) < 4);
        k_clear = ($urandom_range(0, 99) < 2);
        rst     = ($urandom_range(0, 999) == 0);
        tick();
      end
      {k_clear, k_enter, k_next, k_inc} = 4'b0;
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
